// File: rtl/store_drain_buffer_pkg.sv
// Shared definitions for the store drain buffer.
//   SDB_NUM_DEF / SDB_SEL_DEF : default buffer depth and entry index width
//   ADDR_LEN / DATA_LEN       : store address and data widths
//   sdb_state_e               : drain FSM state encoding
package store_drain_buffer_pkg;

  localparam int SDB_NUM_DEF = 4;
  localparam int SDB_SEL_DEF = 2;
  localparam int ADDR_LEN    = 32;
  localparam int DATA_LEN    = 32;

  typedef enum logic {
    SDB_IDLE  = 1'b0,
    SDB_WRITE = 1'b1
  } sdb_state_e;

endpackage

// File: rtl/store_drain_buffer_fwd_match.sv
// Store-to-load forwarding lookup over the occupied buffer entries.
// Ports:
//   tail       : next free slot; the youngest store sits at tail-1
//   count      : number of occupied entries
//   entry_addr : address held in each slot
//   entry_data : data held in each slot
//   ld_addr    : load address to look up
//   hit / data : youngest matching store (data is 0 when there is no hit)
// Only built when STORE_FWD_EN is defined.
module sdb_fwd_match
  import store_drain_buffer_pkg::*;
#(
  parameter int SDB_NUM = SDB_NUM_DEF,
  parameter int SDB_SEL = SDB_SEL_DEF
) (
  input  logic [SDB_SEL-1:0]                 tail,
  input  logic [SDB_SEL:0]                   count,
  input  logic [SDB_NUM-1:0][ADDR_LEN-1:0]   entry_addr,
  input  logic [SDB_NUM-1:0][DATA_LEN-1:0]   entry_data,
  input  logic [ADDR_LEN-1:0]                ld_addr,
  output logic                               hit,
  output logic [DATA_LEN-1:0]                data
);

  localparam logic [SDB_SEL-1:0] IDX_ONE = SDB_SEL'(1);

  logic [SDB_SEL-1:0] youngest;
  logic [SDB_NUM-1:0] match_vec;

  assign youngest = tail - IDX_ONE;

  // A slot is occupied when its distance back from the youngest entry is
  // below the occupancy count.
  always_comb begin
    logic [SDB_SEL-1:0] age;
    match_vec = '0;
    for (int e = 0; e < SDB_NUM; e++) begin
      age = youngest - SDB_SEL'(e);
      match_vec[e] = (entry_addr[e] == ld_addr) && ({1'b0, age} < count);
    end
  end

  // Walk from oldest to youngest so the youngest match is the last to land.
  always_comb begin
    logic [SDB_SEL-1:0] idx;
    hit  = 1'b0;
    data = '0;
    for (int i = SDB_NUM - 1; i >= 0; i--) begin
      idx = youngest - SDB_SEL'(i);
      if (match_vec[idx]) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Store drain buffer: accepts up to two committed stores per cycle into a
// circular FIFO and drains them in program order to data memory over a
// we/ack handshake.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   commit_valid_1/2, addr, data: older (1) / younger (2) committed stores
//   commit_ready               : at least two free entries
//   dmem_we/addr/wdata, dmem_ack: memory write port, request held until ack
//   ld_addr, fwd_hit, fwd_data : forwarding lookup (active with STORE_FWD_EN)
//   sdb_empty, sdb_count       : occupancy status
//   sdb_overflow               : sticky, a push arrived while not ready
// Build option: define STORE_FWD_EN to enable store-to-load forwarding;
// otherwise fwd_hit/fwd_data are tied to zero.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int SDB_NUM = SDB_NUM_DEF,
  parameter int SDB_SEL = SDB_SEL_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  commit_valid_1,
  input  logic                  commit_valid_2,
  input  logic [ADDR_LEN-1:0]   commit_addr_1,
  input  logic [ADDR_LEN-1:0]   commit_addr_2,
  input  logic [DATA_LEN-1:0]   commit_data_1,
  input  logic [DATA_LEN-1:0]   commit_data_2,
  output logic                  commit_ready,
  output logic                  dmem_we,
  output logic [ADDR_LEN-1:0]   dmem_addr,
  output logic [DATA_LEN-1:0]   dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [ADDR_LEN-1:0]   ld_addr,
  output logic                  fwd_hit,
  output logic [DATA_LEN-1:0]   fwd_data,
  output logic                  sdb_empty,
  output logic [SDB_SEL:0]      sdb_count,
  output logic                  sdb_overflow
);

  localparam logic [SDB_SEL-1:0] IDX_ONE   = SDB_SEL'(1);
  localparam logic [SDB_SEL-1:0] IDX_TWO   = SDB_SEL'(2);
  localparam logic [SDB_SEL:0]   CNT_ONE   = (SDB_SEL + 1)'(1);
  localparam logic [SDB_SEL:0]   CNT_TWO   = (SDB_SEL + 1)'(2);
  localparam logic [SDB_SEL:0]   CNT_READY = (SDB_SEL + 1)'(SDB_NUM - 2);

  logic [SDB_NUM-1:0][ADDR_LEN-1:0] addr_q, addr_d;
  logic [SDB_NUM-1:0][DATA_LEN-1:0] data_q, data_d;
  logic [SDB_SEL-1:0]               head_q, head_d;
  logic [SDB_SEL-1:0]               tail_q, tail_d;
  logic [SDB_SEL:0]                 count_q, count_d;
  sdb_state_e                       state_q, state_d;
  logic                             dmem_we_q, dmem_we_d;
  logic [ADDR_LEN-1:0]              dmem_addr_q, dmem_addr_d;
  logic [DATA_LEN-1:0]              dmem_wdata_q, dmem_wdata_d;
  logic                             overflow_q, overflow_d;
  logic [SDB_SEL:0]                 push_cnt;
  logic                             pop;

  assign commit_ready = (count_q <= CNT_READY);
  assign sdb_empty    = (count_q == '0);
  assign sdb_count    = count_q;
  assign sdb_overflow = overflow_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;

  // Push side. A push that arrives while not ready is dropped entirely.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    tail_d     = tail_q;
    push_cnt   = '0;
    overflow_d = overflow_q;
    if (commit_valid_1 || commit_valid_2) begin
      if (!commit_ready) begin
        overflow_d = 1'b1;
      end else if (commit_valid_1 && commit_valid_2) begin
        addr_d[tail_q]           = commit_addr_1;
        data_d[tail_q]           = commit_data_1;
        addr_d[tail_q + IDX_ONE] = commit_addr_2;
        data_d[tail_q + IDX_ONE] = commit_data_2;
        tail_d                   = tail_q + IDX_TWO;
        push_cnt                 = CNT_TWO;
      end else if (commit_valid_1) begin
        addr_d[tail_q] = commit_addr_1;
        data_d[tail_q] = commit_data_1;
        tail_d         = tail_q + IDX_ONE;
        push_cnt       = CNT_ONE;
      end else begin
        addr_d[tail_q] = commit_addr_2;
        data_d[tail_q] = commit_data_2;
        tail_d         = tail_q + IDX_ONE;
        push_cnt       = CNT_ONE;
      end
    end
  end

  // Drain FSM. The memory request is registered, so address/data stay
  // stable for as long as we is held. On ack with more already-buffered
  // entries behind the head, the next one is presented back-to-back; a store
  // pushed during the ack cycle is picked up from IDLE one cycle later.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    pop          = 1'b0;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      SDB_IDLE: begin
        if (count_q != '0) begin
          state_d      = SDB_WRITE;
          dmem_we_d    = 1'b1;
          dmem_addr_d  = addr_q[head_q];
          dmem_wdata_d = data_q[head_q];
        end
      end
      SDB_WRITE: begin
        if (dmem_ack) begin
          pop    = 1'b1;
          head_d = head_q + IDX_ONE;
          if (count_q > CNT_ONE) begin
            dmem_addr_d  = addr_q[head_q + IDX_ONE];
            dmem_wdata_d = data_q[head_q + IDX_ONE];
          end else begin
            state_d   = SDB_IDLE;
            dmem_we_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = SDB_IDLE;
        dmem_we_d = 1'b0;
      end
    endcase
  end

  assign count_d = count_q + push_cnt - (SDB_SEL + 1)'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= SDB_IDLE;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef STORE_FWD_EN
  sdb_fwd_match #(
    .SDB_NUM (SDB_NUM),
    .SDB_SEL (SDB_SEL)
  ) u_fwd_match (
    .tail       (tail_q),
    .count      (count_q),
    .entry_addr (addr_q),
    .entry_data (data_q),
    .ld_addr    (ld_addr),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );
`else
  logic ld_addr_unused;
  assign ld_addr_unused = ^ld_addr;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                commit_valid_1, commit_valid_2;
  logic [ADDR_LEN-1:0] commit_addr_1, commit_addr_2;
  logic [DATA_LEN-1:0] commit_data_1, commit_data_2;
  logic                commit_ready;
  logic                dmem_we;
  logic [ADDR_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;
  logic                dmem_ack;
  logic [ADDR_LEN-1:0] ld_addr;
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;
  logic                sdb_empty;
  logic [2:0]          sdb_count;
  logic                sdb_overflow;

  int total = 0;
  int bad   = 0;

  store_drain_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid_1 (commit_valid_1),
    .commit_valid_2 (commit_valid_2),
    .commit_addr_1  (commit_addr_1),
    .commit_addr_2  (commit_addr_2),
    .commit_data_1  (commit_data_1),
    .commit_data_2  (commit_data_2),
    .commit_ready   (commit_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .ld_addr        (ld_addr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data),
    .sdb_empty      (sdb_empty),
    .sdb_count      (sdb_count),
    .sdb_overflow   (sdb_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] a2, input logic [31:0] d2);
    commit_valid_1 = v1; commit_addr_1 = a1; commit_data_1 = d1;
    commit_valid_2 = v2; commit_addr_2 = a2; commit_data_2 = d2;
  endtask

  task automatic idle_in();
    push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},    dmem_we,      0);
    chk({tag, "_addr"},  dmem_addr,    0);
    chk({tag, "_wdata"}, dmem_wdata,   0);
    chk({tag, "_count"}, sdb_count,    0);
    chk({tag, "_empty"}, sdb_empty,    1);
    chk({tag, "_ready"}, commit_ready, 1);
    chk({tag, "_ovf"},   sdb_overflow, 0);
    chk({tag, "_hit"},   fwd_hit,      0);
    chk({tag, "_fdata"}, fwd_data,     0);
  endtask

  logic [31:0] exp_addr [0:7];
  logic [31:0] exp_cnt  [0:7];
  logic        exp_we   [0:7];

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    ld_addr = 32'h0;
    idle_in();
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // T2: dual commit, ack every cycle, consecutive drain
    dmem_ack = 1'b1;
    push(1'b1, 32'h10, 32'hA, 1'b1, 32'h14, 32'hB);
    tick();
    idle_in();
    chk("t2_cnt_push", sdb_count, 2);
    chk("t2_we_push",  dmem_we, 0);
    chk("t2_rdy_push", commit_ready, 1);
    tick();
    chk("t2_we1",    dmem_we, 1);
    chk("t2_addr1",  dmem_addr, 32'h10);
    chk("t2_data1",  dmem_wdata, 32'hA);
    tick();
    chk("t2_we2",    dmem_we, 1);
    chk("t2_addr2",  dmem_addr, 32'h14);
    chk("t2_data2",  dmem_wdata, 32'hB);
    chk("t2_cnt2",   sdb_count, 1);
    tick();
    chk("t2_we_end", dmem_we, 0);
    chk("t2_empty",  sdb_empty, 1);
    chk("t2_cnt0",   sdb_count, 0);

    // T3: fill with ack held low, then overflow attempt
    dmem_ack = 1'b0;
    push(1'b1, 32'h40, 32'h1, 1'b1, 32'h44, 32'h2);
    tick();
    chk("t3_cnt2", sdb_count, 2);
    push(1'b1, 32'h48, 32'h3, 1'b1, 32'h4C, 32'h4);
    tick();
    chk("t3_cnt4",  sdb_count, 4);
    chk("t3_rdy0",  commit_ready, 0);
    chk("t3_we",    dmem_we, 1);
    chk("t3_addr",  dmem_addr, 32'h40);
    push(1'b1, 32'h50, 32'h5, 1'b0, 32'h0, 32'h0);
    tick();
    idle_in();
    chk("t3_ovf",      sdb_overflow, 1);
    chk("t3_cnt_ovf",  sdb_count, 4);
    chk("t3_hold_we",  dmem_we, 1);
    chk("t3_hold_adr", dmem_addr, 32'h40);
    chk("t3_hold_dat", dmem_wdata, 32'h1);
    dmem_ack = 1'b1;
    tick();
    chk("t3_d1_addr", dmem_addr, 32'h44);
    chk("t3_d1_cnt",  sdb_count, 3);
    tick();
    chk("t3_d2_addr", dmem_addr, 32'h48);
    tick();
    chk("t3_d3_addr", dmem_addr, 32'h4C);
    chk("t3_d3_data", dmem_wdata, 32'h4);
    chk("t3_d3_cnt",  sdb_count, 1);
    tick();
    chk("t3_d4_we",   dmem_we, 0);
    chk("t3_d4_cnt",  sdb_count, 0);
    chk("t3_ovf_sticky", sdb_overflow, 1);

    // T1: reset while a write is outstanding
    dmem_ack = 1'b0;
    push(1'b1, 32'h60, 32'h7, 1'b0, 32'h0, 32'h0);
    tick();
    idle_in();
    tick();
    chk("t1_we_before", dmem_we, 1);
    chk("t1_addr_before", dmem_addr, 32'h60);
    reset = 1'b1;
    tick();
    chk_reset_state("t1");
    reset = 1'b0;

    // T4: younger way only
    push(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 32'hC);
    tick();
    idle_in();
    chk("t4_cnt", sdb_count, 1);
    tick();
    chk("t4_we",   dmem_we, 1);
    chk("t4_addr", dmem_addr, 32'h20);
    chk("t4_data", dmem_wdata, 32'hC);
    dmem_ack = 1'b1;
    tick();
    chk("t4_we_end", dmem_we, 0);
    chk("t4_empty",  sdb_empty, 1);

    // T5: push and pop in the same cycle, indices wrap
    exp_we[0] = 1'b0; exp_cnt[0] = 1; exp_addr[0] = 32'h0;
    exp_we[1] = 1'b1; exp_cnt[1] = 2; exp_addr[1] = 32'h100;
    exp_we[2] = 1'b1; exp_cnt[2] = 2; exp_addr[2] = 32'h104;
    exp_we[3] = 1'b1; exp_cnt[3] = 2; exp_addr[3] = 32'h108;
    exp_we[4] = 1'b1; exp_cnt[4] = 2; exp_addr[4] = 32'h10C;
    exp_we[5] = 1'b1; exp_cnt[5] = 2; exp_addr[5] = 32'h110;
    exp_we[6] = 1'b1; exp_cnt[6] = 1; exp_addr[6] = 32'h114;
    exp_we[7] = 1'b0; exp_cnt[7] = 0; exp_addr[7] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) push(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0, 32'h0);
      else       idle_in();
      tick();
      chk($sformatf("t5_we_%0d", i),  dmem_we, exp_we[i]);
      chk($sformatf("t5_cnt_%0d", i), sdb_count, exp_cnt[i]);
      if (exp_we[i]) begin
        chk($sformatf("t5_addr_%0d", i), dmem_addr, exp_addr[i]);
        chk($sformatf("t5_data_%0d", i), dmem_wdata, exp_addr[i] - 32'h100 + 32'h4 >> 2);
      end
    end
    idle_in();

    // T6: forwarding, youngest match wins
    dmem_ack = 1'b0;
    ld_addr = 32'h30;
    push(1'b1, 32'h30, 32'h1, 1'b1, 32'h30, 32'h2);
    #1;
    chk("t6_same_cycle_hit", fwd_hit, 0);
    tick();
    idle_in();
    chk("t6_hit",  fwd_hit, FWD ? 32'd1 : 32'd0);
    chk("t6_data", fwd_data, FWD ? 32'h2 : 32'h0);
    ld_addr = 32'h34;
    #1;
    chk("t6_miss_hit",  fwd_hit, 0);
    chk("t6_miss_data", fwd_data, 0);
    ld_addr = 32'h30;
    tick();
    chk("t6_inwrite_hit", fwd_hit, FWD ? 32'd1 : 32'd0);
    chk("t6_inwrite_data", fwd_data, FWD ? 32'h2 : 32'h0);
    dmem_ack = 1'b1;
    tick();
    chk("t6_one_left_data", fwd_data, FWD ? 32'h2 : 32'h0);
    tick();
    chk("t6_empty_hit", fwd_hit, 0);
    chk("t6_empty_cnt", sdb_count, 0);
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
